reg_bank_sequencer: RTL and testbench



---
 rtl/reg_seq_pkg.sv | 46 ++++
 rtl/reg_seq_step_gen.sv | 50 +++++
 rtl/reg_bank_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_reg_bank_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register-bank sequencer: op codes,
// FSM states, bank function-select codes and per-op step counts.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        OP_LOAD     = 3'd0,
        OP_CLEAR    = 3'd1,
        OP_INC_N    = 3'd2,
        OP_DEC_N    = 3'd3,
        OP_LOAD32_B = 3'd4,
        OP_SEXT16   = 3'd5,
        OP_RSVD6    = 3'd6,
        OP_RSVD7    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Function-select codes understood by the register bank.
    localparam logic [2:0] FS_DEC    = 3'b000;
    localparam logic [2:0] FS_INC    = 3'b001;
    localparam logic [2:0] FS_LOAD   = 3'b010;
    localparam logic [2:0] FS_CLR    = 3'b011;
    localparam logic [2:0] FS_LOAD8  = 3'b100;
    localparam logic [2:0] FS_LOAD16 = 3'b101;
    localparam logic [2:0] FS_SHL8   = 3'b110;
    localparam logic [2:0] FS_SEXT16 = 3'b111;

    // Number of bank steps an op issues; reserved ops issue none.
    function automatic logic [7:0] op_step_count(input op_e op, input logic [7:0] count);
        case (op)
            OP_LOAD, OP_CLEAR, OP_SEXT16: return 8'd1;
            OP_INC_N, OP_DEC_N:           return count;
            OP_LOAD32_B:                  return 8'd4;
            default:                      return 8'd0;
        endcase
    endfunction

    function automatic logic op_is_reserved(input op_e op);
        return (op == OP_RSVD6) || (op == OP_RSVD7);
    endfunction

endpackage

// File: rtl/reg_seq_step_gen.sv
// Combinational step decoder: given the op, its latched operand and the
// step index, produce the bank FunSel and data input for that step.
module reg_seq_step_gen
    import reg_seq_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] data,
    input  logic [1:0]  step_idx,
    output logic [2:0]  fun_sel,
    output logic [31:0] i_data
);

    logic [7:0] byte_sel;

    // Byte-serial load walks the operand from the most significant byte down.
    always_comb begin
        case (step_idx)
            2'd0:    byte_sel = data[31:24];
            2'd1:    byte_sel = data[23:16];
            2'd2:    byte_sel = data[15:8];
            default: byte_sel = data[7:0];
        endcase
    end

    // Per-op FunSel and data; data stays 0 for ops that do not consume it.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        fun_sel = FS_DEC;
        i_data  = '0;
        case (op)
            OP_LOAD: begin
                fun_sel = FS_LOAD;
                i_data  = data;
            end
            OP_CLEAR:  fun_sel = FS_CLR;
            OP_INC_N:  fun_sel = FS_INC;
            OP_DEC_N:  fun_sel = FS_DEC;
            OP_LOAD32_B: begin
                fun_sel = (step_idx == 2'd0) ? FS_LOAD8 : FS_SHL8;
                i_data  = {24'd0, byte_sel};
            end
            OP_SEXT16: begin
                fun_sel = FS_SEXT16;
                i_data  = data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Register-bank sequencer: accepts one request at a time and replays it as
// a sequence of single-cycle bank operations, then pulses done.
// Optional feature macro: REG_SEQ_BOUNDS_CHECK_EN (out-of-range select or
// reserved op completes immediately with err=1; otherwise select wraps and
// reserved ops are zero-step no-ops).
module reg_bank_sequencer
    import reg_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
)
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [SEL_W-1:0]    req_sel,
    input  logic [31:0]         req_data,
    output logic [NUM_REGS-1:0] reg_E,
    output logic [2:0]          reg_FunSel,
    output logic [31:0]         reg_I,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [31:0]         data_q, data_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [NUM_REGS-1:0] reg_e_q, reg_e_d;
    logic [2:0]          fun_sel_q, fun_sel_d;
    logic [31:0]         reg_i_q, reg_i_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    op_e                 req_op_e;
    logic [SEL_W-1:0]    req_sel_mod;
    logic                req_bad;
    logic [7:0]          req_steps;

    op_e                 gen_op;
    logic [31:0]         gen_data;
    logic [1:0]          gen_idx;
    logic [2:0]          gen_fun_sel;
    logic [31:0]         gen_i;

    logic [SEL_W-1:0]    run_sel;
    logic                drive_step;

    assign req_op_e    = op_e'(req_op);
    assign req_sel_mod = SEL_W'(int'(req_sel) % NUM_REGS);

`ifdef REG_SEQ_BOUNDS_CHECK_EN
    assign req_bad = (int'(req_sel) >= NUM_REGS) || op_is_reserved(req_op_e);
`else
    assign req_bad = 1'b0;
`endif

    assign req_steps = req_bad ? 8'd0 : op_step_count(req_op_e, req_data[7:0]);

    // Step decoder sees the live request on accept, the latched one while running.
    always_comb begin
        gen_op   = op_q;
        gen_data = data_q;
        gen_idx  = idx_q + 2'd1;
        if (state_q == ST_IDLE) begin
            gen_op   = req_op_e;
            gen_data = req_data;
            gen_idx  = 2'd0;
        end
    end

    reg_seq_step_gen u_step_gen (
        .op       (gen_op),
        .data     (gen_data),
        .step_idx (gen_idx),
        .fun_sel  (gen_fun_sel),
        .i_data   (gen_i)
    );

    // Next-state and next-output logic; outputs are registered one cycle ahead.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        reg_e_d    = '0;
        fun_sel_d  = FS_DEC;
        reg_i_d    = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        run_sel    = sel_q;
        drive_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op_e;
                    sel_d  = req_sel_mod;
                    data_d = req_data;
                    cnt_d  = req_steps;
                    idx_d  = 2'd0;
                    if (req_steps == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = req_bad;
                    end else begin
                        state_d    = ST_RUN;
                        drive_step = 1'b1;
                        run_sel    = req_sel_mod;
                    end
                end
            end
            // cnt_q counts the steps left including the one on the bank now.
            ST_RUN: begin
                if (cnt_q == 8'd1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d      = cnt_q - 8'd1;
                    idx_d      = idx_q + 2'd1;
                    drive_step = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (drive_step) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_e_d[i] = (run_sel == SEL_W'(i));
            end
            fun_sel_d = gen_fun_sel;
            reg_i_d   = gen_i;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            sel_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            reg_e_q   <= '0;
            fun_sel_q <= FS_DEC;
            reg_i_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            reg_e_q   <= reg_e_d;
            fun_sel_q <= fun_sel_d;
            reg_i_q   <= reg_i_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign reg_E      = reg_e_q;
    assign reg_FunSel = fun_sel_q;
    assign reg_I      = reg_i_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Scoreboard bench for reg_bank_sequencer. The stimulus side pushes the
// expected bank steps and completion records derived from each op's meaning;
// a negedge monitor pops and compares them against what the DUT drives and
// keeps a model bank fed by the DUT's enables to compare final register values.
module tb_reg_bank_sequencer;

    localparam int NUM_REGS = 4;
    localparam int SEL_W    = 2;

    logic                Clock = 1'b0;
    logic                Reset = 1'b1;
    logic                req_valid = 1'b0;
    logic [2:0]          req_op = 3'd0;
    logic [SEL_W-1:0]    req_sel = '0;
    logic [31:0]         req_data = 32'd0;
    logic                req_ready;
    logic [NUM_REGS-1:0] reg_E;
    logic [2:0]          reg_FunSel;
    logic [31:0]         reg_I;
    logic                busy;
    logic                done;
    logic                err;

    always #5 Clock = ~Clock;

    reg_bank_sequencer #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .reg_E      (reg_E),
        .reg_FunSel (reg_FunSel),
        .reg_I      (reg_I),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [NUM_REGS-1:0] e;
        logic [2:0]          fs;
        logic [31:0]         i;
        bit                  i_chk;
    } step_t;

    typedef struct {
        int          sel;
        logic [31:0] val;
        bit          err;
        int          steps;
        int          acc;
    } txn_t;

    step_t       step_q[$];
    txn_t        txn_q[$];
    logic [31:0] ref_bank[NUM_REGS];
    logic [31:0] obs_bank[NUM_REGS];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_step(input logic [NUM_REGS-1:0] e, input logic [2:0] fs,
                             input logic [31:0] i, input bit i_chk);
        step_t s;
        s.e = e; s.fs = fs; s.i = i; s.i_chk = i_chk;
        step_q.push_back(s);
    endtask

    // Reference: what each op means for the target register and which bank steps it needs.
    task automatic model_issue(input logic [2:0] op, input int sel, input logic [31:0] data, input int acc);
        txn_t                t;
        int                  n;
        bit                  bad;
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        bad = 1'b0;
`ifdef REG_SEQ_BOUNDS_CHECK_EN
        bad = (op >= 3'd6) || (sel >= NUM_REGS);
`endif
        n = 0;
        if (!bad) begin
            case (op)
                3'd0: begin push_step(oh, 3'b010, data, 1'b1); ref_bank[sel] = data; n = 1; end
                3'd1: begin push_step(oh, 3'b011, 32'd0, 1'b0); ref_bank[sel] = 32'd0; n = 1; end
                3'd2: begin
                    n = int'(data[7:0]);
                    for (int k = 0; k < n; k++) push_step(oh, 3'b001, 32'd0, 1'b0);
                    ref_bank[sel] = ref_bank[sel] + {24'd0, data[7:0]};
                end
                3'd3: begin
                    n = int'(data[7:0]);
                    for (int k = 0; k < n; k++) push_step(oh, 3'b000, 32'd0, 1'b0);
                    ref_bank[sel] = ref_bank[sel] - {24'd0, data[7:0]};
                end
                3'd4: begin
                    push_step(oh, 3'b100, {24'd0, data[31:24]}, 1'b1);
                    push_step(oh, 3'b110, {24'd0, data[23:16]}, 1'b1);
                    push_step(oh, 3'b110, {24'd0, data[15:8]},  1'b1);
                    push_step(oh, 3'b110, {24'd0, data[7:0]},   1'b1);
                    ref_bank[sel] = data;
                    n = 4;
                end
                3'd5: begin
                    push_step(oh, 3'b111, data, 1'b1);
                    ref_bank[sel] = {{16{data[15]}}, data[15:0]};
                    n = 1;
                end
                default: ;
            endcase
        end
        t.sel = sel; t.val = ref_bank[sel]; t.err = bad; t.steps = n; t.acc = acc;
        txn_q.push_back(t);
    endtask

    // Present a request, wait (bounded) for the handshake, record expectations.
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] data,
                         input bit hold, output int acc);
        int waited;
        waited    = 0;
        acc       = -1;
        req_valid = 1'b1;
        req_op    = op;
        req_sel   = sel;
        req_data  = data;
        @(negedge Clock);
        while (!req_ready && waited < 600) begin
            waited++;
            @(negedge Clock);
        end
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        model_issue(op, int'(sel), data, acc);
        @(posedge Clock);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_op    = 3'($urandom);
            req_sel   = SEL_W'($urandom);
            req_data  = $urandom;
        end
    endtask

    // Model bank: applies whatever the DUT enables, as the real bank would.
    task automatic bank_apply();
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_E[r]) begin
                case (reg_FunSel)
                    3'b000: obs_bank[r] = obs_bank[r] - 32'd1;
                    3'b001: obs_bank[r] = obs_bank[r] + 32'd1;
                    3'b010: obs_bank[r] = reg_I;
                    3'b011: obs_bank[r] = 32'd0;
                    3'b100: obs_bank[r] = {24'd0, reg_I[7:0]};
                    3'b101: obs_bank[r] = {16'd0, reg_I[15:0]};
                    3'b110: obs_bank[r] = {obs_bank[r][23:0], reg_I[7:0]};
                    default: obs_bank[r] = {{16{reg_I[15]}}, reg_I[15:0]};
                endcase
            end
        end
    endtask

    step_t mon_s;
    txn_t  mon_t;

    // Monitor: compare each driven step and each completion against the queues.
    always @(negedge Clock) begin
        if (mon_en) begin
            check("ready_vs_busy", 64'(req_ready), 64'(!busy));
            check("E_onehot", 64'($countones(reg_E) <= 1), 64'd1);
            if (reg_E != '0) begin
                if (step_q.size() == 0) begin
                    check("unexpected_step", 64'(reg_E), 64'd0);
                end else begin
                    mon_s = step_q.pop_front();
                    check("step_E", 64'(reg_E), 64'(mon_s.e));
                    check("step_FunSel", 64'(reg_FunSel), 64'(mon_s.fs));
                    if (mon_s.i_chk) check("step_I", 64'(reg_I), 64'(mon_s.i));
                end
                bank_apply();
            end
            if (err && !done) check("err_without_done", 64'(err), 64'd0);
            if (done) begin
                check("done_E_zero", 64'(reg_E), 64'd0);
                if (txn_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_t = txn_q.pop_front();
                    check("done_latency", 64'(cyc - mon_t.acc), 64'(mon_t.steps));
                    check("done_err", 64'(err), 64'(mon_t.err));
                    check("reg_value", 64'(obs_bank[mon_t.sel]), 64'(mon_t.val));
                    check("steps_consumed", 64'(step_q.size()), 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc_prev;
        int b2b_ops[4];
        int b2b_data[4];
        int b2b_steps[4];
        int waited;
        logic [2:0]  rop;
        logic [31:0] rdata;
        bit          rhold;

        for (int r = 0; r < NUM_REGS; r++) begin
            ref_bank[r] = 32'd0;
            obs_bank[r] = 32'd0;
        end

        // Reset with a request present: it must be ignored.
        req_valid = 1'b1; req_op = 3'd0; req_sel = 2'd1; req_data = 32'hA5A5A5A5;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_E", 64'(reg_E), 64'd0);
        check("rst_FunSel", 64'(reg_FunSel), 64'd0);
        check("rst_I", 64'(reg_I), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        @(posedge Clock);
        #1;
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Define every register, then the directed cases.
        for (int r = 0; r < NUM_REGS; r++) issue(3'd1, 2'(r), $urandom, 1'b0, acc);
        issue(3'd0, 2'd2, 32'hDEADBEEF, 1'b0, acc);
        issue(3'd4, 2'd1, 32'h12345678, 1'b0, acc);
        issue(3'd1, 2'd0, 32'd0, 1'b0, acc);
        issue(3'd2, 2'd0, 32'h00000003, 1'b0, acc);
        issue(3'd3, 2'd0, 32'hFFFFFF00, 1'b0, acc);
        issue(3'd5, 2'd3, 32'h00008001, 1'b0, acc);
        issue(3'd5, 2'd2, 32'h12347FFF, 1'b0, acc);
        issue(3'd6, 2'd3, 32'h00000005, 1'b0, acc);
        issue(3'd7, 2'd1, 32'h00000001, 1'b0, acc);

        // Back-to-back with valid held: each accept lands exactly when ready returns.
        b2b_ops   = '{0, 3, 2, 4};
        b2b_data  = '{32'h0BADF00D, 32'h00000000, 32'h00000002, 32'hCAFE1234};
        b2b_steps = '{1, 0, 2, 4};
        acc_prev  = -1;
        for (int k = 0; k < 4; k++) begin
            issue(3'(b2b_ops[k]), 2'(k), 32'(b2b_data[k]), (k != 3), acc);
            if (k > 0) check("b2b_spacing", 64'(acc - acc_prev), 64'(b2b_steps[k-1] + 2));
            acc_prev = acc;
        end

        // Longest count.
        issue(3'd2, 2'd2, 32'h000000FF, 1'b0, acc);

        // Reset during step 2 of INC_N count 10: two increments land, no done.
        req_valid = 1'b1; req_op = 3'd2; req_sel = 2'd0; req_data = 32'd10;
        waited = 0;
        @(negedge Clock);
        while (!req_ready && waited < 600) begin
            waited++;
            @(negedge Clock);
        end
        check("abort_accept", 64'(req_ready), 64'd1);
        push_step(4'b0001, 3'b001, 32'd0, 1'b0);
        push_step(4'b0001, 3'b001, 32'd0, 1'b0);
        ref_bank[0] = ref_bank[0] + 32'd2;
        @(posedge Clock);
        #1 req_valid = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check("abort_E", 64'(reg_E), 64'd0);
        check("abort_FunSel", 64'(reg_FunSel), 64'd0);
        check("abort_I", 64'(reg_I), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_steps", 64'(step_q.size()), 64'd0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        // Zero-count op on the aborted register exposes its partial value at done.
        issue(3'd2, 2'd0, 32'h00000000, 1'b0, acc);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            rop   = 3'($urandom_range(0, 7));
            rdata = $urandom;
            if (rop == 3'd2 || rop == 3'd3) rdata[7:0] = 8'($urandom_range(0, 5));
            rhold = (k != 59) && ($urandom_range(0, 1) == 1);
            issue(rop, 2'($urandom_range(0, NUM_REGS - 1)), rdata, rhold, acc);
            if (!rhold) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge Clock);
                    #1;
                end
            end
        end

        waited = 0;
        while (txn_q.size() != 0 && waited < 1000) begin
            waited++;
            @(negedge Clock);
        end
        check("drain_txn", 64'(txn_q.size()), 64'd0);
        check("drain_steps", 64'(step_q.size()), 64'd0);
        repeat (3) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
